// File: rtl/mac_pkg.sv
// Shared MAC datapath types: FloPoCo exception codes and the 66-bit FloPoCo word.
package mac_pkg;

  localparam int unsigned WE   = 11;
  localparam int unsigned WF   = 52;
  localparam int unsigned FP_W = WE + WF + 3;

  typedef enum logic [1:0] {
    EXN_ZERO   = 2'b00,
    EXN_NORMAL = 2'b01,
    EXN_INF    = 2'b10,
    EXN_NAN    = 2'b11
  } exn_t;

  typedef struct packed {
    exn_t            exn;
    logic            sign;
    logic [WE-1:0]   exp;
    logic [WF-1:0]   frac;
  } flopoco_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ieee_to_flopoco.sv
// IEEE binary64 to FloPoCo float converter: decode, LATENCY-deep valid/data pipe,
// and saturating statistics for subnormal, infinity and NaN inputs.
module ieee_to_flopoco
  import mac_pkg::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_in,
  input  logic [63:0]      ieee_float,
  output logic             push_out,
  output logic [FP_W-1:0]  flopoco_float,
  input  logic             clear_stats,
  output logic [CNT_W-1:0] cnt_denorm,
  output logic [CNT_W-1:0] cnt_inf,
  output logic [CNT_W-1:0] cnt_nan
);

  logic [WE-1:0] exp_in;
  logic [WF-1:0] frac_in;
  logic          exp_zero_c;
  logic          exp_max_c;
  logic          frac_zero_c;
  flopoco_t      dec_c;

  assign exp_in      = ieee_float[62:52];
  assign frac_in     = ieee_float[51:0];
  assign exp_zero_c  = (exp_in == '0);
  assign exp_max_c   = (exp_in == {WE{1'b1}});
  assign frac_zero_c = (frac_in == '0);

  // Bias matches between formats, so normals pass through bit-exact; specials carry only sign.
  always_comb begin
    dec_c      = '0;
    dec_c.sign = ieee_float[63];
    if (exp_zero_c) begin
      dec_c.exn = EXN_ZERO;
    end else if (exp_max_c) begin
      dec_c.exn = frac_zero_c ? EXN_INF : EXN_NAN;
    end else begin
      dec_c.exn  = EXN_NORMAL;
      dec_c.exp  = exp_in;
      dec_c.frac = frac_in;
    end
  end

  logic [LATENCY-1:0] vld;
  flopoco_t           dat [LATENCY];

  // Stage 0 captures the decoded word; later stages are a plain delay line.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < int'(LATENCY); i++) dat[i] <= '0;
    end else begin
      vld[0] <= push_in;
      dat[0] <= dec_c;
      for (int i = 1; i < int'(LATENCY); i++) begin
        vld[i] <= vld[i-1];
        dat[i] <= dat[i-1];
      end
    end
  end

  assign push_out      = vld[LATENCY-1];
  assign flopoco_float = dat[LATENCY-1];

  sat_counter #(.CNT_W(CNT_W)) u_cnt_denorm (
    .clk   (clk),
    .rst   (rst),
    .inc   (push_in && exp_zero_c && !frac_zero_c),
    .clr   (clear_stats),
    .count (cnt_denorm)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_inf (
    .clk   (clk),
    .rst   (rst),
    .inc   (push_in && exp_max_c && frac_zero_c),
    .clr   (clear_stats),
    .count (cnt_inf)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt_nan (
    .clk   (clk),
    .rst   (rst),
    .inc   (push_in && exp_max_c && !frac_zero_c),
    .clr   (clear_stats),
    .count (cnt_nan)
  );

endmodule

// File: tb/tb_ieee_to_flopoco.sv
// Bench for ieee_to_flopoco: three instances (LATENCY 2/1/4, CNT_W 32/4/4) share one stimulus
// stream and are checked every cycle against a cycle-history reference model.
module tb_ieee_to_flopoco;

  localparam int unsigned NI = 3;
  localparam int unsigned LAT [NI] = '{2, 1, 4};
  localparam int unsigned CW  [NI] = '{32, 4, 4};
  localparam int unsigned HN = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push_in = 1'b0;
  logic        clear_stats = 1'b0;
  logic [63:0] ieee_float = '0;

  always #5 clk = ~clk;

  logic        d0_po, d1_po, d2_po;
  logic [65:0] d0_ff, d1_ff, d2_ff;
  logic [31:0] d0_cd, d0_ci, d0_cn;
  logic [3:0]  d1_cd, d1_ci, d1_cn, d2_cd, d2_ci, d2_cn;

  ieee_to_flopoco #(.LATENCY(2), .CNT_W(32)) dut0 (
    .clk(clk), .rst(rst), .push_in(push_in), .ieee_float(ieee_float),
    .push_out(d0_po), .flopoco_float(d0_ff), .clear_stats(clear_stats),
    .cnt_denorm(d0_cd), .cnt_inf(d0_ci), .cnt_nan(d0_cn));
  ieee_to_flopoco #(.LATENCY(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .push_in(push_in), .ieee_float(ieee_float),
    .push_out(d1_po), .flopoco_float(d1_ff), .clear_stats(clear_stats),
    .cnt_denorm(d1_cd), .cnt_inf(d1_ci), .cnt_nan(d1_cn));
  ieee_to_flopoco #(.LATENCY(4), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .push_in(push_in), .ieee_float(ieee_float),
    .push_out(d2_po), .flopoco_float(d2_ff), .clear_stats(clear_stats),
    .cnt_denorm(d2_cd), .cnt_inf(d2_ci), .cnt_nan(d2_cn));

  logic        op [NI];
  logic [65:0] of [NI];
  logic [31:0] cd [NI], ci [NI], cn [NI];
  assign op[0] = d0_po;  assign op[1] = d1_po;  assign op[2] = d2_po;
  assign of[0] = d0_ff;  assign of[1] = d1_ff;  assign of[2] = d2_ff;
  assign cd[0] = d0_cd;  assign cd[1] = 32'(d1_cd); assign cd[2] = 32'(d2_cd);
  assign ci[0] = d0_ci;  assign ci[1] = 32'(d1_ci); assign ci[2] = 32'(d2_ci);
  assign cn[0] = d0_cn;  assign cn[1] = 32'(d1_cn); assign cn[2] = 32'(d2_cn);

  int vecs = 0;
  int errs = 0;

  // Reference model state: full input history plus expected outputs after the latest edge.
  int          n = -1;
  logic        hpush [HN];
  logic        hrst  [HN];
  logic [63:0] hdata [HN];
  logic        e_push [NI];
  logic        e_fchk [NI];
  logic [65:0] e_float [NI];
  longint      e_cd [NI], e_ci [NI], e_cn [NI];

  function automatic logic is_sub(input logic [63:0] x);
    return (x[62:52] == 11'd0) && (x[51:0] != 52'd0);
  endfunction
  function automatic logic is_inf(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] == 52'd0);
  endfunction
  function automatic logic is_nan(input logic [63:0] x);
    return (x[62:52] == 11'h7FF) && (x[51:0] != 52'd0);
  endfunction

  function automatic logic [65:0] ref_conv(input logic [63:0] x);
    if (x[62:52] == 11'd0) return {2'b00, x[63], 63'd0};
    if (is_inf(x))         return {2'b10, x[63], 63'd0};
    if (is_nan(x))         return {2'b11, x[63], 63'd0};
    return {2'b01, x};
  endfunction

  function automatic logic [63:0] rand_ieee();
    logic [63:0] x;
    x = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0: x[62:52] = 11'(1 + $urandom_range(0, 2045));
      1: x[62:0]  = '0;
      2: begin x[62:52] = '0; if (x[51:0] == '0) x[0] = 1'b1; end
      3: begin x[62:52] = 11'h7FF; x[51:0] = '0; end
      4: begin x[62:52] = 11'h7FF; if (x[51:0] == '0) x[51] = 1'b1; end
      default: ;
    endcase
    return x;
  endfunction

  task automatic step(input logic p, input logic [63:0] d, input logic c, input logic r);
    int k;
    longint maxv;
    push_in = p; ieee_float = d; clear_stats = c; rst = r;
    @(posedge clk);
    n++;
    hpush[n] = p; hdata[n] = d; hrst[n] = r;
    for (int i = 0; i < int'(NI); i++) begin
      k = n - int'(LAT[i]) + 1;
      e_push[i] = (k >= 0) && hpush[k];
      if (k >= 0) for (int m = k; m <= n; m++) if (hrst[m]) e_push[i] = 1'b0;
      e_fchk[i]  = e_push[i] || r;
      e_float[i] = r ? 66'd0 : (e_push[i] ? ref_conv(hdata[k]) : 66'd0);
      maxv = (longint'(1) << CW[i]) - 1;
      if (r || c) begin
        e_cd[i] = 0; e_ci[i] = 0; e_cn[i] = 0;
      end else if (p) begin
        if (is_sub(d) && e_cd[i] < maxv) e_cd[i]++;
        if (is_inf(d) && e_ci[i] < maxv) e_ci[i]++;
        if (is_nan(d) && e_cn[i] < maxv) e_cn[i]++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    int rise [NI];
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 64'h3FF0000000000000, 1'b0, 1'b1);
      for (int i = 0; i < int'(NI); i++) begin
        vecs++;
        if (op[i] !== 1'b0 || of[i] !== 66'd0 || cd[i] !== 0 || ci[i] !== 0 || cn[i] !== 0) begin
          errs++;
          $display("FAIL reset_state L=%0d got po=%0b ff=%h cnt=%0d/%0d/%0d want all zero",
                   LAT[i], op[i], of[i], cd[i], ci[i], cn[i]);
        end
      end
    end
    step(1'b1, 64'h3FF0000000000000, 1'b0, 1'b0);
    for (int i = 0; i < int'(NI); i++) rise[i] = 0;
    for (int j = 1; j <= 6; j++) begin
      for (int i = 0; i < int'(NI); i++) if (rise[i] == 0 && op[i] === 1'b1) rise[i] = j;
      step(1'b0, 64'd0, 1'b0, 1'b0);
    end
    for (int i = 0; i < int'(NI); i++) begin
      vecs++;
      if (rise[i] != int'(LAT[i])) begin
        errs++;
        $display("FAIL reset_first_latency L=%0d got %0d cycles want %0d", LAT[i], rise[i], LAT[i]);
      end
    end
  endtask

  task automatic test_values();
    logic [63:0] vin  [6];
    logic [65:0] vexp [6];
    vin[0] = 64'h3FF0000000000000; vexp[0] = 66'h1_3FF0000000000000;
    vin[1] = 64'hC000000000000000; vexp[1] = {2'b01, 1'b1, 11'h400, 52'd0};
    vin[2] = 64'h7FF0000000000000; vexp[2] = {2'b10, 1'b0, 63'd0};
    vin[3] = 64'hFFF8000000000001; vexp[3] = {2'b11, 1'b1, 63'd0};
    vin[4] = 64'h8000000000000000; vexp[4] = {2'b00, 1'b1, 63'd0};
    vin[5] = 64'h0000000000000001; vexp[5] = {2'b00, 1'b0, 63'd0};
    step(1'b0, 64'd0, 1'b0, 1'b1);
    for (int j = 0; j < 6; j++) begin
      for (int s = 0; s < 2; s++) begin
        step(s == 0, vin[j], 1'b0, 1'b0);
        for (int i = 0; i < int'(NI); i++) begin
          vecs++;
          if (op[i] !== e_push[i] || (e_fchk[i] && of[i] !== e_float[i])) begin
            errs++;
            $display("FAIL values_pipe L=%0d got po=%0b ff=%h want po=%0b ff=%h",
                     LAT[i], op[i], of[i], e_push[i], e_float[i]);
          end
          vecs++;
          if (cd[i] !== 32'(e_cd[i]) || ci[i] !== 32'(e_ci[i]) || cn[i] !== 32'(e_cn[i])) begin
            errs++;
            $display("FAIL values_cnt L=%0d got %0d/%0d/%0d want %0d/%0d/%0d",
                     LAT[i], cd[i], ci[i], cn[i], e_cd[i], e_ci[i], e_cn[i]);
          end
        end
      end
      vecs++;
      if (d0_po !== 1'b1 || d0_ff !== vexp[j]) begin
        errs++;
        $display("FAIL value_%0d in=%h got po=%0b ff=%h want po=1 ff=%h", j, vin[j], d0_po, d0_ff, vexp[j]);
      end
    end
    vecs++;
    if (d0_cd !== 32'd1 || d0_ci !== 32'd1 || d0_cn !== 32'd1) begin
      errs++;
      $display("FAIL special_counts got denorm=%0d inf=%0d nan=%0d want 1/1/1", d0_cd, d0_ci, d0_cn);
    end
  endtask

  task automatic test_streaming();
    logic pat [13];
    for (int j = 0; j < 8; j++) pat[j] = 1'b1;
    pat[8] = 1'b1; pat[9] = 1'b0; pat[10] = 1'b1; pat[11] = 1'b1; pat[12] = 1'b0;
    for (int j = 0; j < 18; j++) begin
      step((j < 13) ? pat[j] : 1'b0, rand_ieee(), 1'b0, 1'b0);
      for (int i = 0; i < int'(NI); i++) begin
        vecs++;
        if (op[i] !== e_push[i] || (e_fchk[i] && of[i] !== e_float[i])) begin
          errs++;
          $display("FAIL stream L=%0d slot %0d got po=%0b ff=%h want po=%0b ff=%h",
                   LAT[i], j, op[i], of[i], e_push[i], e_float[i]);
        end
      end
    end
  endtask

  task automatic test_saturation();
    step(1'b0, 64'd0, 1'b0, 1'b1);
    for (int j = 0; j < 20; j++) begin
      step(1'b1, 64'h7FF0000000000123, 1'b0, 1'b0);
      for (int i = 0; i < int'(NI); i++) begin
        vecs++;
        if (cn[i] !== 32'(e_cn[i])) begin
          errs++;
          $display("FAIL sat_ramp L=%0d push %0d got %0d want %0d", LAT[i], j, cn[i], e_cn[i]);
        end
      end
    end
    vecs++;
    if (cn[1] !== 32'd15 || cn[2] !== 32'd15 || cn[0] !== 32'd20) begin
      errs++;
      $display("FAIL sat_hold got %0d/%0d/%0d want 20/15/15", cn[0], cn[1], cn[2]);
    end
    step(1'b1, 64'h7FF0000000000123, 1'b1, 1'b0);
    vecs++;
    if (cn[0] !== 32'd0 || cn[1] !== 32'd0 || cn[2] !== 32'd0) begin
      errs++;
      $display("FAIL clear_priority got %0d/%0d/%0d want 0/0/0", cn[0], cn[1], cn[2]);
    end
  endtask

  task automatic test_random();
    step(1'b0, 64'd0, 1'b0, 1'b1);
    for (int j = 0; j < 400; j++) begin
      step($urandom_range(0, 3) != 0, rand_ieee(), $urandom_range(0, 40) == 0,
           $urandom_range(0, 70) == 0);
      for (int i = 0; i < int'(NI); i++) begin
        vecs++;
        if (op[i] !== e_push[i] || (e_fchk[i] && of[i] !== e_float[i])) begin
          errs++;
          $display("FAIL random_pipe L=%0d cyc %0d got po=%0b ff=%h want po=%0b ff=%h",
                   LAT[i], j, op[i], of[i], e_push[i], e_float[i]);
        end
        vecs++;
        if (cd[i] !== 32'(e_cd[i]) || ci[i] !== 32'(e_ci[i]) || cn[i] !== 32'(e_cn[i])) begin
          errs++;
          $display("FAIL random_cnt L=%0d cyc %0d got %0d/%0d/%0d want %0d/%0d/%0d",
                   LAT[i], j, cd[i], ci[i], cn[i], e_cd[i], e_ci[i], e_cn[i]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < int'(NI); i++) begin
      e_cd[i] = 0; e_ci[i] = 0; e_cn[i] = 0;
    end
    test_reset();
    test_values();
    test_streaming();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish within time bound");
    $fatal(1);
  end

endmodule
